sevenseg_scan_driver: RTL and testbench

Parametrised, time-multiplexed hex display driver for common-anode seven-segment banks. It holds a `DIGITS`-nibble value and scans one digit per refresh slot, decoding 0–F to active-low segments. It applies leading-zero blanking correctly and drives per-digit decimal points. New values load tear-free: a loaded value takes effect only at a frame boundary. The block sits between the datapath register that produces the display value and the board's anode/segment pins.

---
 rtl/sevenseg_scan_driver_if.sv | 23 ++
 rtl/sevenseg_scan_driver.sv | 151 +++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_driver_if.sv
// Display-value and pin bundle between the datapath, the scan driver and the board.
interface sevenseg_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic                load;
    logic                enable;
    logic [DIGITS-1:0]   AN;
    logic [6:0]          SEG;
    logic                DP;
    logic                frame_tick;

    modport master (
        output value, dp, load, enable,
        input  AN, SEG, DP, frame_tick
    );

    modport slave (
        input  value, dp, load, enable,
        output AN, SEG, DP, frame_tick
    );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed hex driver for common-anode seven-segment banks with
// tear-free (frame-boundary) value updates and leading-zero blanking.
module sevenseg_scan_driver #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_LZ    = 1
) (
    input logic clk,
    input logic rst,
    sevenseg_scan_driver_if.slave bus
);
    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VAL_W-1:0]  pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_out_q, dp_out_d;
    logic              frame_tick_q, frame_tick_d;

    logic              boundary_c;
    logic [3:0]        nib_c;
    logic              dp_sel_c;
    logic              upper_nz_c;
    logic              blank_c;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Scan counters, pending capture and frame-boundary transfer.
    always_comb begin
        div_d      = div_q;
        idx_d      = idx_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        boundary_c = 1'b0;

        if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp;
        end

        if (bus.enable) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d      = '0;
                    boundary_c = 1'b1;
                    // Old pending value wins when a load lands on the boundary.
                    act_val_d  = pend_val_q;
                    act_dp_d   = pend_dp_q;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Outputs decode the slot being entered so frame_tick lines up with new digit 0.
    always_comb begin
        nib_c      = 4'h0;
        dp_sel_c   = 1'b0;
        upper_nz_c = 1'b0;
        an_d       = '1;
        seg_d      = 7'h7F;
        dp_out_d   = 1'b1;
        frame_tick_d = boundary_c;

        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nib_c    = act_val_d[4*i +: 4];
                dp_sel_c = act_dp_d[i];
            end
            if ((IDX_W'(i) >= idx_d) && (act_val_d[4*i +: 4] != 4'h0)) begin
                upper_nz_c = 1'b1;
            end
        end
        blank_c = (BLANK_LZ != 0) && (idx_d != '0) && !upper_nz_c;

        if (bus.enable) begin
            if (!blank_c || dp_sel_c) begin
                an_d = ~(DIGITS'(1) << idx_d);
            end
            if (!blank_c) begin
                seg_d = hex_to_seg(nib_c);
            end
            dp_out_d = ~dp_sel_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_out_q     <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.AN         = an_q;
    assign bus.SEG        = seg_q;
    assign bus.DP         = dp_out_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with DIGITS=4, REFRESH_DIV=4, BLANK_LZ=1.
module tb_sevenseg_scan_driver;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    sevenseg_scan_driver_if #(.DIGITS(4)) ifc ();

    sevenseg_scan_driver #(
        .DIGITS(4),
        .REFRESH_DIV(4),
        .BLANK_LZ(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] an, input logic [6:0] seg,
                              input logic dp, input logic ft);
        chk({tag, ".AN"},  32'(ifc.AN),         32'(an));
        chk({tag, ".SEG"}, 32'(ifc.SEG),        32'(seg));
        chk({tag, ".DP"},  32'(ifc.DP),         32'(dp));
        chk({tag, ".ft"},  32'(ifc.frame_tick), 32'(ft));
    endtask

    // Checks n consecutive cycles of one slot, stepping after each.
    task automatic check_digit(input string tag, input logic ft_first, input int n,
                               input logic [3:0] an, input logic [6:0] seg, input logic dp);
        for (int c = 0; c < n; c++) begin
            expect_out(tag, an, seg, dp, (c == 0) ? ft_first : 1'b0);
            step();
        end
    endtask

    // Digit 0 in the low field of each packed argument; starts on a tick cycle.
    task automatic check_frame(input string tag, input logic [15:0] an4,
                               input logic [27:0] seg4, input logic [3:0] dp4);
        for (int d = 0; d < 4; d++) begin
            check_digit($sformatf("%s.d%0d", tag, d), (d == 0), 4,
                        an4[d*4 +: 4], seg4[d*7 +: 7], dp4[d]);
        end
    endtask

    task automatic wait_tick(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (ifc.frame_tick !== 1'b1 && k < 40);
        chk({tag, ".tick_timeout"}, 32'(ifc.frame_tick), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        ifc.value = v;
        ifc.dp    = d;
        ifc.load  = 1'b1;
        step();
        ifc.load  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        ifc.value  = '0;
        ifc.dp     = '0;
        ifc.load   = 1'b0;
        ifc.enable = 1'b1;
        step();
        step();
        expect_out("reset", 4'hF, 7'h7F, 1'b1, 1'b0);

        rst = 1'b0;
        step();
        expect_out("release", 4'hE, 7'h40, 1'b1, 1'b0);

        do_load(16'h1234, 4'h0);
        wait_tick("w1234");
        check_frame("f1234", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);

        // BEEF loaded during digit 1: rest of this frame must still show 1234
        check_digit("bf.d0", 1'b1, 4, 4'hE, 7'h19, 1'b1);
        ifc.value = 16'hBEEF;
        ifc.load  = 1'b1;
        check_digit("bf.d1a", 1'b0, 1, 4'hD, 7'h30, 1'b1);
        ifc.load  = 1'b0;
        check_digit("bf.d1b", 1'b0, 3, 4'hD, 7'h30, 1'b1);
        check_digit("bf.d2", 1'b0, 4, 4'hB, 7'h24, 1'b1);
        check_digit("bf.d3", 1'b0, 4, 4'h7, 7'h79, 1'b1);
        check_frame("fBEEF", 16'h7BDE, {7'h03, 7'h06, 7'h06, 7'h0E}, 4'hF);

        // 1111 loaded on the boundary edge: BEEF shows one more frame
        check_digit("bd.d0", 1'b1, 4, 4'hE, 7'h0E, 1'b1);
        check_digit("bd.d1", 1'b0, 4, 4'hD, 7'h06, 1'b1);
        check_digit("bd.d2", 1'b0, 4, 4'hB, 7'h06, 1'b1);
        check_digit("bd.d3", 1'b0, 3, 4'h7, 7'h03, 1'b1);
        do_load(16'h1111, 4'h0);
        check_frame("fBEEF2", 16'h7BDE, {7'h03, 7'h06, 7'h06, 7'h0E}, 4'hF);
        check_frame("f1111", 16'h7BDE, {7'h79, 7'h79, 7'h79, 7'h79}, 4'hF);

        do_load(16'h0005, 4'h0);
        wait_tick("w0005");
        check_frame("f0005", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'hF);

        do_load(16'h0000, 4'h0);
        wait_tick("w0000");
        check_frame("f0000", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);

        do_load(16'h0A0F, 4'h0);
        wait_tick("w0A0F");
        check_frame("f0A0F", 16'hFBDE, {7'h7F, 7'h08, 7'h40, 7'h0E}, 4'hF);

        do_load(16'h00C0, 4'b0100);
        wait_tick("w00C0");
        check_frame("f00C0", 16'hFBDE, {7'h7F, 7'h7F, 7'h46, 7'h40}, 4'b1011);

        // Disable for 10 cycles after digit 0 has been lit 3 cycles
        check_digit("en.d0a", 1'b1, 2, 4'hE, 7'h40, 1'b1);
        ifc.enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            expect_out($sformatf("dark%0d", c), 4'hF, 7'h7F, 1'b1, 1'b0);
        end
        ifc.enable = 1'b1;
        step();
        check_digit("en.d0b", 1'b0, 1, 4'hE, 7'h40, 1'b1);
        check_digit("en.d1", 1'b0, 4, 4'hD, 7'h46, 1'b1);
        check_digit("en.d2", 1'b0, 4, 4'hB, 7'h7F, 1'b0);
        check_digit("en.d3", 1'b0, 4, 4'hF, 7'h7F, 1'b1);
        chk("en.tick_resume", 32'(ifc.frame_tick), 32'd1);

        // Reset while slot 2 is lit
        check_digit("mr.d0", 1'b1, 4, 4'hE, 7'h40, 1'b1);
        check_digit("mr.d1", 1'b0, 4, 4'hD, 7'h46, 1'b1);
        check_digit("mr.d2", 1'b0, 1, 4'hB, 7'h7F, 1'b0);
        rst = 1'b1;
        ifc.value = 16'h9999;
        ifc.load  = 1'b1;
        step();
        expect_out("midrst", 4'hF, 7'h7F, 1'b1, 1'b0);
        rst = 1'b0;
        ifc.load = 1'b0;
        step();
        expect_out("midrst.rel", 4'hE, 7'h40, 1'b1, 1'b0);
        wait_tick("wrst");
        check_frame("frst", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
